// File: rtl/op_seq_ctrl.sv
// rtl/op_seq_ctrl.sv - operation sequencer FSM: key edges, error countdown, retries
// Optional feature: define OP_SEQ_RUN_WATCHDOG_EN to enable the OP_RUN watchdog timeout.
module op_seq_ctrl #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int CNT_W       = 8,
  parameter int ID_W        = 4,
  parameter int OP_W        = 3,
  parameter int MAX_RETRY   = 3,
  parameter int RUN_TIMEOUT = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        key,
  input  logic [OP_W+2:0]   sw,
  input  logic [CNT_W-1:0]  cfg_countdown,
  input  logic              error_flag,
  input  logic              done_flag,
  input  logic              format_done,
  input  logic              select_done,
  input  logic              select_error,
  input  logic [ID_W-1:0]   selected_a,
  input  logic [ID_W-1:0]   selected_b,
  output logic [1:0]        mode_sel,
  output logic [OP_W-1:0]   op_sel,
  output logic [CNT_W-1:0]  countdown_val,
  output logic              start_input,
  output logic              start_gen,
  output logic              start_op,
  output logic              start_select,
  output logic              start_format,
  output logic [1:0]        display_mode,
  output logic              manual_mode,
  output logic [ID_W-1:0]   operand_a_id,
  output logic [ID_W-1:0]   operand_b_id,
  output logic [1:0]        retry_cnt,
  output logic              timeout_flag,
  output logic [3:0]        state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_MENU        = 4'd1,
    S_INPUT       = 4'd2,
    S_GEN         = 4'd3,
    S_GEN_SHOW    = 4'd4,
    S_DISPLAY     = 4'd5,
    S_OP_SELECT   = 4'd6,
    S_OP_SHOW_LIST= 4'd7,
    S_OP_OPERAND  = 4'd8,
    S_OP_RUN      = 4'd9,
    S_OP_RESULT   = 4'd10,
    S_ERROR       = 4'd11
  } state_t;

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_key_q;
  logic [3:0]       r_key_pls;
  logic [PW-1:0]    r_presc;
  logic             w_sec_tick;
  logic             w_presc_en;
  logic             w_enter;
  logic             w_err_exit;
  logic             w_ok;
  logic             w_back;
  logic             w_nxt;
  logic             w_qm;
  logic [CNT_W-1:0] r_countdown;
  logic [1:0]       r_retry;

  assign w_ok       = r_key_pls[0];
  assign w_back     = r_key_pls[1];
  assign w_nxt      = r_key_pls[2];
  assign w_qm       = r_key_pls[3];
  assign w_sec_tick = (r_presc == PRESC_LAST);
  assign w_enter    = (w_next != r_state);

  assign countdown_val = r_countdown;
  assign retry_cnt     = r_retry;
  assign state_dbg     = r_state;

`ifdef OP_SEQ_RUN_WATCHDOG_EN
  localparam int SW = (RUN_TIMEOUT > 1) ? $clog2(RUN_TIMEOUT + 1) : 1;
  localparam logic [SW-1:0] WD_LAST = SW'(RUN_TIMEOUT - 1);

  logic [SW-1:0] r_wd_sec;
  logic          r_timeout;
  logic          w_wd_expire;
  logic          w_to_take;

  assign w_wd_expire  = (r_state == S_OP_RUN) && w_sec_tick && (r_wd_sec == WD_LAST);
  assign timeout_flag = r_timeout;

  // Whole seconds spent in OP_RUN since entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_sec <= '0;
    end else if (w_enter && w_next == S_OP_RUN) begin
      r_wd_sec <= '0;
    end else if (r_state == S_OP_RUN && w_sec_tick && r_wd_sec != WD_LAST) begin
      r_wd_sec <= r_wd_sec + SW'(1);
    end
  end

  // Sticky timeout indicator, dropped when the user is back at the menu
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeout <= 1'b0;
    end else if (w_next == S_MENU) begin
      r_timeout <= 1'b0;
    end else if (w_to_take) begin
      r_timeout <= 1'b1;
    end
  end
`else
  assign timeout_flag = 1'b0;
`endif

  // Press-edge detection: history starts released so reset never fakes a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_q   <= 4'hF;
      r_key_pls <= 4'h0;
    end else begin
      r_key_q   <= key;
      r_key_pls <= r_key_q & ~key;
    end
  end

  // The one-second prescaler only runs while a seconds count is being kept
  always_comb begin
    w_presc_en = (r_state == S_ERROR);
`ifdef OP_SEQ_RUN_WATCHDOG_EN
    if (r_state == S_OP_RUN) begin
      w_presc_en = 1'b1;
    end
`endif
  end

  // One-second prescaler, restarted on every entry to a timed state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_enter && (w_next == S_ERROR || w_next == S_OP_RUN)) begin
      r_presc <= '0;
    end else if (w_presc_en) begin
      r_presc <= w_sec_tick ? '0 : r_presc + PW'(1);
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: quick-menu beats error_flag beats the per-state rules
  always_comb begin
    w_next     = r_state;
    w_err_exit = 1'b0;
`ifdef OP_SEQ_RUN_WATCHDOG_EN
    w_to_take  = 1'b0;
`endif
    if (r_state > S_ERROR) begin
      w_next = S_IDLE;
    end else if (w_qm && r_state != S_IDLE && r_state != S_MENU) begin
      w_next = S_MENU;
    end else if (error_flag && r_state != S_IDLE && r_state != S_MENU && r_state != S_ERROR) begin
      w_next = S_ERROR;
    end else begin
      case (r_state)
        S_IDLE: w_next = S_MENU;
        S_MENU: begin
          if (w_ok) begin
            case (sw[1:0])
              2'd0:    w_next = S_INPUT;
              2'd1:    w_next = S_GEN;
              2'd2:    w_next = S_DISPLAY;
              default: w_next = S_OP_SELECT;
            endcase
          end
        end
        S_INPUT:   if (w_back) w_next = S_MENU;
        S_GEN:     if (done_flag) w_next = S_GEN_SHOW;
        S_GEN_SHOW: begin
          if (w_back) w_next = S_MENU;
          else if (w_ok && format_done) w_next = S_GEN;
        end
        S_DISPLAY: if (w_back) w_next = S_MENU;
        S_OP_SELECT: begin
          if (w_back) w_next = S_MENU;
          else if (w_ok) w_next = S_OP_SHOW_LIST;
        end
        S_OP_SHOW_LIST: begin
          if (w_back) w_next = S_OP_SELECT;
          else if (format_done || w_ok) w_next = S_OP_OPERAND;
        end
        S_OP_OPERAND: begin
          if (select_error) w_next = S_ERROR;
          else if (w_back) w_next = S_OP_SELECT;
          else if (select_done && w_ok) w_next = S_OP_RUN;
        end
        S_OP_RUN: begin
          if (done_flag) begin
            w_next = S_OP_RESULT;
          end
`ifdef OP_SEQ_RUN_WATCHDOG_EN
          else if (w_wd_expire) begin
            w_next    = S_ERROR;
            w_to_take = 1'b1;
          end
`endif
        end
        S_OP_RESULT: begin
          if (w_ok && format_done) w_next = S_OP_OPERAND;
          else if (w_nxt) w_next = S_OP_SELECT;
          else if (w_back) w_next = S_MENU;
        end
        S_ERROR: begin
          if (r_countdown == '0 || w_back) begin
            w_err_exit = 1'b1;
            w_next     = (32'(r_retry) < MAX_RETRY) ? S_OP_OPERAND : S_MENU;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Entry pulses land in the first cycle of the new state; DISPLAY also re-formats on next
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_input  <= 1'b0;
      start_gen    <= 1'b0;
      start_select <= 1'b0;
      start_op     <= 1'b0;
      start_format <= 1'b0;
    end else begin
      start_input  <= w_enter && (w_next == S_INPUT);
      start_gen    <= w_enter && (w_next == S_GEN);
      start_select <= w_enter && (w_next == S_OP_OPERAND);
      start_op     <= w_enter && (w_next == S_OP_RUN);
      start_format <= (w_enter && (w_next == S_GEN_SHOW || w_next == S_DISPLAY ||
                                   w_next == S_OP_SHOW_LIST || w_next == S_OP_RESULT)) ||
                      (r_state == S_DISPLAY && w_next == S_DISPLAY && w_nxt);
    end
  end

  // Display mode chosen on entry to a showing state, held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      display_mode <= 2'd0;
    end else if (w_enter) begin
      case (w_next)
        S_GEN_SHOW, S_DISPLAY: display_mode <= 2'd0;
        S_OP_SHOW_LIST:        display_mode <= 2'd1;
        S_OP_RESULT:           display_mode <= 2'd2;
        default:               display_mode <= display_mode;
      endcase
    end
  end

  // Op code follows the switches only while choosing it; operand ids latch on selector done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_sel       <= '0;
      manual_mode  <= 1'b0;
      operand_a_id <= '0;
      operand_b_id <= '0;
    end else begin
      manual_mode <= sw[OP_W+2];
      if (r_state == S_OP_SELECT) begin
        op_sel <= sw[OP_W+1:2];
      end
      if (r_state == S_OP_OPERAND && select_done) begin
        operand_a_id <= selected_a;
        operand_b_id <= selected_b;
      end
    end
  end

  // Error countdown: loaded on ERROR entry, one step per second, zeroed at the menu
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_countdown <= '0;
    end else if (w_next == S_MENU) begin
      r_countdown <= '0;
    end else if (w_enter && w_next == S_ERROR) begin
      r_countdown <= cfg_countdown;
    end else if (r_state == S_ERROR && w_sec_tick && r_countdown != '0) begin
      r_countdown <= r_countdown - CNT_W'(1);
    end
  end

  // Recovery counter: bumps on each ERROR->OP_OPERAND return, restarts per operation choice
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retry <= 2'd0;
    end else if (w_next == S_MENU) begin
      r_retry <= 2'd0;
    end else if (w_enter && w_next == S_OP_SELECT) begin
      r_retry <= 2'd0;
    end else if (w_err_exit && w_next == S_OP_OPERAND) begin
      r_retry <= r_retry + 2'd1;
    end
  end

  // Coarse mode reported to the datapath
  always_comb begin
    mode_sel = 2'd3;
    case (r_state)
      S_IDLE, S_MENU:    mode_sel = 2'd0;
      S_INPUT:           mode_sel = 2'd1;
      S_GEN, S_GEN_SHOW: mode_sel = 2'd2;
      default:           mode_sel = 2'd3;
    endcase
  end

endmodule

// File: tb/tb_op_seq_ctrl.sv
// tb/tb_op_seq_ctrl.sv - directed + randomized check of op_seq_ctrl against a reference model
module tb_op_seq_ctrl;
  localparam int CLK_FREQ    = 10;
  localparam int CNT_W       = 8;
  localparam int ID_W        = 4;
  localparam int OP_W        = 3;
  localparam int MAX_RETRY   = 3;
  localparam int RUN_TIMEOUT = 2;

  logic clk;
  logic rst;
  logic [3:0] key;
  logic [OP_W+2:0] sw;
  logic [CNT_W-1:0] cfg_countdown;
  logic error_flag, done_flag, format_done, select_done, select_error;
  logic [ID_W-1:0] selected_a, selected_b;
  logic [1:0] mode_sel;
  logic [OP_W-1:0] op_sel;
  logic [CNT_W-1:0] countdown_val;
  logic start_input, start_gen, start_op, start_select, start_format;
  logic [1:0] display_mode;
  logic manual_mode;
  logic [ID_W-1:0] operand_a_id, operand_b_id;
  logic [1:0] retry_cnt;
  logic timeout_flag;
  logic [3:0] state_dbg;

  op_seq_ctrl #(
    .CLK_FREQ(CLK_FREQ), .CNT_W(CNT_W), .ID_W(ID_W), .OP_W(OP_W),
    .MAX_RETRY(MAX_RETRY), .RUN_TIMEOUT(RUN_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .key(key), .sw(sw), .cfg_countdown(cfg_countdown),
    .error_flag(error_flag), .done_flag(done_flag), .format_done(format_done),
    .select_done(select_done), .select_error(select_error),
    .selected_a(selected_a), .selected_b(selected_b),
    .mode_sel(mode_sel), .op_sel(op_sel), .countdown_val(countdown_val),
    .start_input(start_input), .start_gen(start_gen), .start_op(start_op),
    .start_select(start_select), .start_format(start_format),
    .display_mode(display_mode), .manual_mode(manual_mode),
    .operand_a_id(operand_a_id), .operand_b_id(operand_b_id),
    .retry_cnt(retry_cnt), .timeout_flag(timeout_flag), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model (spec rules, seconds as cycle counts) ----------------
  logic [3:0] m_kprev = 4'hF;
  logic [3:0] m_kpls = 4'h0;
  int m_state = 0, m_retry = 0, m_cd = 0, m_cfg = 0, m_err_k = 0, m_run_k = 0;
  int m_disp = 0, m_op = 0, m_a = 0, m_b = 0, m_manual = 0, m_to = 0;
  bit m_si = 0, m_sg = 0, m_ss = 0, m_so = 0, m_sf = 0;

  function automatic int menu_dest(input logic [1:0] m);
    case (m)
      2'd0: return 2;
      2'd1: return 3;
      2'd2: return 5;
      default: return 6;
    endcase
  endfunction

  function automatic int mode_of(input int s);
    if (s <= 1) return 0;
    if (s == 2) return 1;
    if (s == 3 || s == 4) return 2;
    return 3;
  endfunction

  initial forever begin
    int ns;
    bit ok, bk, nx, qm, took_to, wd_exp, ent;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_kprev = 4'hF; m_kpls = 4'h0; m_state = 0; m_retry = 0; m_cd = 0; m_cfg = 0;
      m_err_k = 0; m_run_k = 0; m_disp = 0; m_op = 0; m_a = 0; m_b = 0; m_manual = 0;
      m_to = 0; m_si = 0; m_sg = 0; m_ss = 0; m_so = 0; m_sf = 0;
    end else begin
      ok = m_kpls[0]; bk = m_kpls[1]; nx = m_kpls[2]; qm = m_kpls[3];
      took_to = 0;
      wd_exp = 0;
`ifdef OP_SEQ_RUN_WATCHDOG_EN
      wd_exp = (m_state == 9) && (m_run_k == CLK_FREQ * RUN_TIMEOUT - 1);
`endif
      ns = m_state;
      if (qm && m_state > 1) ns = 1;
      else if (error_flag && m_state > 1 && m_state != 11) ns = 11;
      else begin
        case (m_state)
          0: ns = 1;
          1: if (ok) ns = menu_dest(sw[1:0]);
          2: if (bk) ns = 1;
          3: if (done_flag) ns = 4;
          4: if (bk) ns = 1; else if (ok && format_done) ns = 3;
          5: if (bk) ns = 1;
          6: if (bk) ns = 1; else if (ok) ns = 7;
          7: if (bk) ns = 6; else if (format_done || ok) ns = 8;
          8: if (select_error) ns = 11; else if (bk) ns = 6; else if (select_done && ok) ns = 9;
          9: if (done_flag) ns = 10; else if (wd_exp) begin ns = 11; took_to = 1; end
          10: if (ok && format_done) ns = 8; else if (nx) ns = 6; else if (bk) ns = 1;
          11: if (m_cd == 0 || bk) begin
                if (m_retry < MAX_RETRY) begin ns = 8; m_retry++; end
                else ns = 1;
              end
          default: ns = 0;
        endcase
      end
      ent = (ns != m_state);
      if (m_state == 11) begin
        m_err_k++;
        m_cd = m_cfg - m_err_k / CLK_FREQ;
        if (m_cd < 0) m_cd = 0;
      end
      if (ent && ns == 11) begin m_cfg = int'(cfg_countdown); m_err_k = 0; m_cd = m_cfg; end
      if (ent && ns == 6) m_retry = 0;
      if (took_to) m_to = 1;
      if (ns == 1) begin m_cd = 0; m_retry = 0; m_to = 0; end
      m_si = ent && ns == 2;
      m_sg = ent && ns == 3;
      m_ss = ent && ns == 8;
      m_so = ent && ns == 9;
      m_sf = (ent && (ns == 4 || ns == 5 || ns == 7 || ns == 10)) || (m_state == 5 && ns == 5 && nx);
      if (ent && (ns == 4 || ns == 5)) m_disp = 0;
      if (ent && ns == 7) m_disp = 1;
      if (ent && ns == 10) m_disp = 2;
      if (m_state == 6) m_op = int'(sw[OP_W+1:2]);
      if (m_state == 8 && select_done) begin m_a = int'(selected_a); m_b = int'(selected_b); end
      m_manual = int'(sw[OP_W+2]);
      if (ent && ns == 9) m_run_k = 0; else if (m_state == 9) m_run_k++;
      m_kpls = m_kprev & ~key;
      m_kprev = key;
      m_state = ns;
    end
  end

  // Per-cycle comparison of every output against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("state", int'(state_dbg), m_state);
      check("mode_sel", int'(mode_sel), mode_of(m_state));
      check("op_sel", int'(op_sel), m_op);
      check("countdown", int'(countdown_val), m_cd);
      check("retry", int'(retry_cnt), m_retry);
      check("timeout", int'(timeout_flag), m_to);
      check("disp_mode", int'(display_mode), m_disp);
      check("manual", int'(manual_mode), m_manual);
      check("opnd_a", int'(operand_a_id), m_a);
      check("opnd_b", int'(operand_b_id), m_b);
      check("pulses", int'({start_input, start_gen, start_select, start_op, start_format}),
            int'({m_si, m_sg, m_ss, m_so, m_sf}));
    end
  end

  int cnt_sf = 0, cnt_ss = 0, cnt_so = 0;
  initial forever begin
    @(negedge clk);
    cnt_sf += int'(start_format);
    cnt_ss += int'(start_select);
    cnt_so += int'(start_op);
  end

  task automatic press(input int i);
    key[i] = 1'b0;
    @(negedge clk);
    key[i] = 1'b1;
    @(negedge clk);
  endtask

  int kprob [4] = '{5, 25, 15, 60};
  int sf0, ss0, so0;

  initial begin
    rst = 1'b1; key = 4'hF; sw = '0; cfg_countdown = '0;
    error_flag = 0; done_flag = 0; format_done = 0; select_done = 0; select_error = 0;
    selected_a = '0; selected_b = '0;
    repeat (2) @(negedge clk);
    check("rst_state", int'(state_dbg), 0);
    check("rst_outs", int'({mode_sel, op_sel, countdown_val, display_mode, operand_a_id,
                            operand_b_id, retry_cnt, timeout_flag, manual_mode}), 0);
    check("rst_pulses", int'({start_input, start_gen, start_op, start_select, start_format}), 0);
    chk_en = 1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_to_menu", int'(state_dbg), 1);

    // menu -> OP_SELECT, then a held ok advances only once
    sw = {1'b0, 3'd5, 2'd3};
    press(0);
    check("menu_to_opsel", int'(state_dbg), 6);
    key[0] = 1'b0;
    repeat (50) @(negedge clk);
    check("held_ok_once", int'(state_dbg), 7);
    key[0] = 1'b1;
    @(negedge clk);
    press(1);
    check("list_back", int'(state_dbg), 6);

    // full operation flow
    @(negedge clk);
    sf0 = cnt_sf; ss0 = cnt_ss; so0 = cnt_so;
    press(0);
    check("list_disp", int'(display_mode), 1);
    format_done = 1; @(negedge clk); format_done = 0;
    check("to_operand", int'(state_dbg), 8);
    selected_a = 4'd3; selected_b = 4'd9; select_done = 1;
    press(0);
    select_done = 0;
    check("to_run", int'(state_dbg), 9);
    done_flag = 1; @(negedge clk); done_flag = 0;
    repeat (2) @(negedge clk);
    check("result_state", int'(state_dbg), 10);
    check("result_op", int'(op_sel), 5);
    check("result_disp", int'(display_mode), 2);
    check("result_a", int'(operand_a_id), 3);
    check("result_b", int'(operand_b_id), 9);
    check("n_format", cnt_sf - sf0, 2);
    check("n_select", cnt_ss - ss0, 1);
    check("n_op", cnt_so - so0, 1);

    // error countdown 3,2,1,0 then retry
    format_done = 1; press(0); format_done = 0;
    check("result_to_operand", int'(state_dbg), 8);
    cfg_countdown = 8'd3;
    select_error = 1; @(negedge clk); select_error = 0;
    check("err_state", int'(state_dbg), 11);
    check("cd3", int'(countdown_val), 3);
    repeat (10) @(negedge clk); check("cd2", int'(countdown_val), 2);
    repeat (10) @(negedge clk); check("cd1", int'(countdown_val), 1);
    repeat (10) @(negedge clk); check("cd0", int'(countdown_val), 0);
    check("cd0_state", int'(state_dbg), 11);
    @(negedge clk);
    check("retry1_state", int'(state_dbg), 8);
    check("retry1", int'(retry_cnt), 1);

    // three more errors with zero countdown: last one aborts to menu
    cfg_countdown = 8'd0;
    for (int i = 0; i < 3; i++) begin
      select_error = 1; @(negedge clk); select_error = 0;
      check("err_n_state", int'(state_dbg), 11);
      @(negedge clk);
      check("err_n_exit", int'(state_dbg), (i < 2) ? 8 : 1);
      check("err_n_retry", int'(retry_cnt), (i < 2) ? i + 2 : 0);
    end

    // OP_RUN watchdog
    press(0); press(0);
    format_done = 1; @(negedge clk); format_done = 0;
    select_done = 1; press(0); select_done = 0;
    check("wd_run", int'(state_dbg), 9);
    repeat (19) @(negedge clk);
    check("wd_before", int'(state_dbg), 9);
    @(negedge clk);
`ifdef OP_SEQ_RUN_WATCHDOG_EN
    check("wd_state", int'(state_dbg), 11);
    check("wd_flag", int'(timeout_flag), 1);
`else
    check("wd_state", int'(state_dbg), 9);
    check("wd_flag", int'(timeout_flag), 0);
`endif
    press(3);
    check("wd_qm_menu", int'(state_dbg), 1);
    check("wd_flag_clr", int'(timeout_flag), 0);

    // quick-menu and error_flag together in GEN
    sw = {1'b0, 3'd5, 2'd1};
    cfg_countdown = 8'd3;
    press(0);
    check("gen_state", int'(state_dbg), 3);
    key[3] = 1'b0; @(negedge clk);
    error_flag = 1; key[3] = 1'b1; @(negedge clk);
    error_flag = 0;
    check("qm_wins", int'(state_dbg), 1);
    check("qm_cd", int'(countdown_val), 0);

    // randomized phase, checked cycle by cycle against the model
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      #1;
      rst = ($urandom_range(0, 1499) == 0);
      for (int i = 0; i < 4; i++) begin
        if (!key[i]) begin
          if ($urandom_range(0, 1) == 0) key[i] = 1'b1;
        end else if ($urandom_range(0, kprob[i]) == 0) begin
          key[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 40) == 0) sw[1:0] = 2'($urandom);
      if ($urandom_range(0, 9) == 0) sw[OP_W+1:2] = 3'($urandom);
      if ($urandom_range(0, 30) == 0) sw[OP_W+2] = ~sw[OP_W+2];
      if ($urandom_range(0, 99) == 0) cfg_countdown = 8'($urandom_range(0, 3));
      error_flag   = ($urandom_range(0, 69) == 0);
      done_flag    = ($urandom_range(0, 7) == 0);
      format_done  = ($urandom_range(0, 2) == 0);
      select_done  = ($urandom_range(0, 2) == 0);
      select_error = ($urandom_range(0, 59) == 0);
      selected_a   = 4'($urandom);
      selected_b   = 4'($urandom);
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
